// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Arbitrates a single synchronous-read data RAM port between the CPU MEM
//   stage (c_*) and a debug requester (d_*). Grants are combinational in the
//   request cycle. Sub-word stores are lane-aligned here: the write mask is
//   shifted by the byte offset and the store data by 8*offset. Read data comes
//   back one cycle after the grant and is tagged to its owner with a one-cycle
//   rvalid pulse.
//
//   Configuration macro: DMEM_ARB_FAIRNESS_EN
//     defined   - a starve counter lets a held debug request win after
//                 STARVE_MAX consecutive denials.
//     undefined - CPU has strict priority; STARVE_MAX is unused.
//
//   Ports
//     clk, rst_n                   clock, async active-low reset
//     c_req/c_we/c_addr/c_wdata    CPU request (held until granted)
//     c_gnt, c_stall, c_rvalid     CPU grant, pipeline stall, read valid
//     d_req/d_we/d_addr/d_wdata    debug request
//     d_gnt, d_rvalid              debug grant, read valid
//     rdata                        read word (valid with either rvalid)
//     ram_we/ram_addr/ram_din      RAM port controls (word address)
//     ram_dout                     RAM read data, one cycle after address
module dmem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_req,
    input  logic [3:0]  c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_stall,
    output logic        c_rvalid,
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] rdata,
    output logic [3:0]  ram_we,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    // Cleared asynchronously by reset and set on the first rising edge with
    // rst_n high. Gating grants with it means a reset pulse that is released
    // before the next edge still kills any grant in that cycle, so no rvalid
    // and no counter update can leak out of the reset cycle.
    logic rst_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_done <= 1'b0;
        else        rst_done <= 1'b1;
    end

    logic c_win, d_win;

`ifdef DMEM_ARB_FAIRNESS_EN
    logic [3:0] starve_cnt;
    logic       starved;

    assign starved = (starve_cnt == 4'(STARVE_MAX));

    always_comb begin
        c_win = c_req && !(d_req && starved);
        d_win = d_req && (!c_req || starved);
    end

    // Counts consecutive cycles the debug request was denied; saturates so a
    // starved debug request keeps winning until it is actually granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= 4'd0;
        else if (!rst_done || !d_req || d_gnt)
            starve_cnt <= 4'd0;
        else if (!starved)
            starve_cnt <= starve_cnt + 4'd1;
    end
`else
    always_comb begin
        c_win = c_req;
        d_win = d_req && !c_req;
    end

    logic [3:0] unused_starve_max;
    assign unused_starve_max = 4'(STARVE_MAX);
`endif

    assign c_gnt   = rst_done && c_win;
    assign d_gnt   = rst_done && d_win;
    assign c_stall = c_req && !c_gnt;

    // Selected request fields; CPU is chosen whenever it holds the grant.
    logic [3:0]  sel_we;
    logic [31:0] sel_addr, sel_wdata;
    logic [1:0]  sel_off;
    logic [3:0]  lane_we;
    logic [31:0] lane_din;
    logic        any_gnt;

    always_comb begin
        sel_we    = c_gnt ? c_we    : d_we;
        sel_addr  = c_gnt ? c_addr  : d_addr;
        sel_wdata = c_gnt ? c_wdata : d_wdata;
        sel_off   = sel_addr[1:0];
        // Full-word stores and loads keep their mask; sub-word masks move to
        // the addressed lane and bits pushed past lane 3 fall off.
        lane_we   = (sel_we == 4'hF || sel_we == 4'h0) ? sel_we : (sel_we << sel_off);
        lane_din  = (sel_we == 4'hF) ? sel_wdata : (sel_wdata << {sel_off, 3'b000});
    end

    assign any_gnt = c_gnt || d_gnt;

    // Address/data outputs hold their last driven values on idle cycles.
    logic [29:0] addr_q;
    logic [31:0] din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= 30'd0;
            din_q  <= 32'd0;
        end else if (any_gnt) begin
            addr_q <= sel_addr[31:2];
            din_q  <= lane_din;
        end
    end

    assign ram_we   = any_gnt ? lane_we         : 4'h0;
    assign ram_addr = any_gnt ? sel_addr[31:2]  : addr_q;
    assign ram_din  = any_gnt ? lane_din        : din_q;

    // The rvalid pair doubles as the read-owner register: exactly one bit is
    // set in the cycle after a granted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end else begin
            c_rvalid <= c_gnt && (c_we == 4'h0);
            d_rvalid <= d_gnt && (d_we == 4'h0);
        end
    end

    assign rdata = ram_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk, rst_n;
    logic        c_req, d_req;
    logic [3:0]  c_we, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] rdata;
    logic [3:0]  ram_we;
    logic [29:0] ram_addr;
    logic [31:0] ram_din, ram_dout;

    dmem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous read, lane writes.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++)
            if (ram_we[l]) mem[ram_addr[9:0]][8*l +: 8] <= ram_din[8*l +: 8];
        ram_dout <= mem[ram_addr[9:0]];
    end

    function automatic logic [31:0] iw(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {8'hC0, b, 8'h5A, b};
    endfunction

    typedef struct { bit port; logic [31:0] data; } sb_t;
    sb_t sbq[$];

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic push(input bit port, input logic [31:0] data);
        sb_t e;
        e.port = port;
        e.data = data;
        sbq.push_back(e);
    endtask

    // Called once per cycle: the entry pushed last cycle (if any) must show
    // up now on exactly its own rvalid.
    task automatic sb_check();
        logic ec, ed;
        ec = (sbq.size() > 0) && (sbq[0].port == 1'b0);
        ed = (sbq.size() > 0) && (sbq[0].port == 1'b1);
        chk1("c_rvalid", c_rvalid, ec);
        chk1("d_rvalid", d_rvalid, ed);
        if (sbq.size() > 0) begin
            if (c_rvalid || d_rvalid) chk("rdata", rdata, sbq[0].data);
            void'(sbq.pop_front());
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        sb_check();
    endtask

    task automatic drv_c(input logic r, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
        c_req = r; c_we = we; c_addr = a; c_wdata = wd;
    endtask

    task automatic drv_d(input logic r, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
        d_req = r; d_we = we; d_addr = a; d_wdata = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        logic        exp_d;
        for (int i = 0; i < 1024; i++) mem[i] = iw(i);

        // Reset: grants and write enables forced off, stall follows c_req.
        rst_n = 1'b0;
        drv_c(1'b1, 4'h0, 32'h104, 32'h0);
        drv_d(1'b1, 4'h0, 32'h20, 32'h0);
        @(negedge clk);
        chk1("rst_c_gnt", c_gnt, 1'b0);
        chk1("rst_d_gnt", d_gnt, 1'b0);
        chk("rst_ram_we", {28'b0, ram_we}, 32'h0);
        chk1("rst_c_stall", c_stall, 1'b1);
        chk1("rst_c_rvalid", c_rvalid, 1'b0);
        chk1("rst_d_rvalid", d_rvalid, 1'b0);
        #1 rst_n = 1'b1;
        drv_d(1'b0, 4'h0, 32'h0, 32'h0);

        // CPU load from 0x104.
        cyc(); mid();
        chk1("ld_c_gnt", c_gnt, 1'b1);
        chk1("ld_d_gnt", d_gnt, 1'b0);
        chk1("ld_c_stall", c_stall, 1'b0);
        chk("ld_ram_addr", {2'b0, ram_addr}, 32'h41);
        chk("ld_ram_we", {28'b0, ram_we}, 32'h0);
        push(1'b0, iw(32'h41));

        // CPU byte store at 0x103.
        cyc(); drv_c(1'b1, 4'b0001, 32'h103, 32'h0000_00AB); mid();
        chk1("sb_c_gnt", c_gnt, 1'b1);
        chk("sb_ram_we", {28'b0, ram_we}, 32'h8);
        chk("sb_ram_din", ram_din, 32'hAB00_0000);
        chk("sb_ram_addr", {2'b0, ram_addr}, 32'h40);

        // CPU half store at 0x202.
        cyc(); drv_c(1'b1, 4'b0011, 32'h202, 32'h0000_1234); mid();
        chk("sh_ram_we", {28'b0, ram_we}, 32'hC);
        chk("sh_ram_din", ram_din, 32'h1234_0000);
        chk("sh_ram_addr", {2'b0, ram_addr}, 32'h80);

        // Idle: no enables, address/data hold.
        cyc(); drv_c(1'b0, 4'h0, 32'h0, 32'h0); mid();
        chk1("idle_c_gnt", c_gnt, 1'b0);
        chk1("idle_c_stall", c_stall, 1'b0);
        chk("idle_ram_we", {28'b0, ram_we}, 32'h0);
        chk("idle_hold_addr", {2'b0, ram_addr}, 32'h80);
        chk("idle_hold_din", ram_din, 32'h1234_0000);

        // Debug load of the word the byte store touched.
        cyc(); drv_d(1'b1, 4'h0, 32'h103, 32'h0); mid();
        chk1("dld_d_gnt", d_gnt, 1'b1);
        chk1("dld_c_gnt", c_gnt, 1'b0);
        w = iw(32'h40);
        push(1'b1, {8'hAB, w[23:0]});

        // Back-to-back: CPU load right after the debug load.
        cyc(); drv_d(1'b0, 4'h0, 32'h0, 32'h0); drv_c(1'b1, 4'h0, 32'h200, 32'h0); mid();
        chk1("b2b_c_gnt", c_gnt, 1'b1);
        w = iw(32'h80);
        push(1'b0, {16'h1234, w[15:0]});

        // Debug word store passes data unshifted.
        cyc(); drv_c(1'b0, 4'h0, 32'h0, 32'h0); drv_d(1'b1, 4'hF, 32'h300, 32'hDEAD_BEEF); mid();
        chk1("dsw_d_gnt", d_gnt, 1'b1);
        chk("dsw_ram_we", {28'b0, ram_we}, 32'hF);
        chk("dsw_ram_din", ram_din, 32'hDEAD_BEEF);
        chk("dsw_ram_addr", {2'b0, ram_addr}, 32'hC0);

        cyc(); drv_d(1'b1, 4'h0, 32'h300, 32'h0); mid();
        push(1'b1, 32'hDEAD_BEEF);

        cyc(); drv_d(1'b0, 4'h0, 32'h0, 32'h0); mid();

        // Sustained contention.
        for (int i = 0; i < 10; i++) begin
            cyc(); drv_c(1'b1, 4'h0, 32'h10, 32'h0); drv_d(1'b1, 4'h0, 32'h20, 32'h0); mid();
`ifdef DMEM_ARB_FAIRNESS_EN
            exp_d = ((i % 5) == 4);
`else
            exp_d = 1'b0;
`endif
            chk1("arb_c_gnt", c_gnt, !exp_d);
            chk1("arb_d_gnt", d_gnt, exp_d);
            chk1("arb_c_stall", c_stall, exp_d);
            push(exp_d, exp_d ? iw(8) : iw(4));
        end

        // CPU drops out: debug is granted.
        cyc(); drv_c(1'b0, 4'h0, 32'h0, 32'h0); mid();
        chk1("solo_d_gnt", d_gnt, 1'b1);
        push(1'b1, iw(8));

        cyc(); drv_d(1'b0, 4'h0, 32'h0, 32'h0); mid();

        // Build up denials, then pulse reset in the cycle of a CPU read.
        for (int i = 0; i < 2; i++) begin
            cyc(); drv_c(1'b1, 4'h0, 32'h10, 32'h0); drv_d(1'b1, 4'h0, 32'h20, 32'h0); mid();
            chk1("pre_c_gnt", c_gnt, 1'b1);
            push(1'b0, iw(4));
        end
        cyc(); mid();
        chk1("rp_c_gnt", c_gnt, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("rp_c_gnt_low", c_gnt, 1'b0);
        chk1("rp_c_stall", c_stall, 1'b1);
        chk1("rp_c_rvalid", c_rvalid, 1'b0);
        #1 rst_n = 1'b1;

        // No rvalid from the killed read; counter restarts from zero.
        for (int j = 0; j < 5; j++) begin
            cyc(); mid();
`ifdef DMEM_ARB_FAIRNESS_EN
            exp_d = (j == 4);
`else
            exp_d = 1'b0;
`endif
            chk1("post_c_gnt", c_gnt, !exp_d);
            chk1("post_d_gnt", d_gnt, exp_d);
            push(exp_d, exp_d ? iw(8) : iw(4));
        end

        cyc(); drv_c(1'b0, 4'h0, 32'h0, 32'h0); drv_d(1'b0, 4'h0, 32'h0, 32'h0); mid();
        cyc(); mid();
        chk("sb_empty", 32'(sbq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
